// File: rtl/mesh_port_arbiter.sv
// Packet-level round-robin arbiter for one outgoing mesh link.
// The grant stays with one requester for a whole wormhole packet and is released after its last flit.
module mesh_port_arbiter #(
  parameter int N_REQ     = 5,
  parameter int DATA_SIZE = 37,
  parameter int PTR_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data_i,
  input  logic [N_REQ-1:0]           req_last_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_SIZE-1:0]       out_data_o,
  output logic                       out_last_o,
  input  logic                       out_ready_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       busy_o
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [N_REQ-1:0]     grant_next;
  logic [N_REQ-1:0]     win_onehot;
  logic                 win_found;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_SIZE-1:0] own_data;
  logic [PTR_W-1:0]     own_idx;
  logic                 can_load;
  logic                 transfer;

  // Search ptr+1, ptr+2, ... (mod N_REQ); the first valid requester wins.
  always_comb begin
    win_found  = 1'b0;
    win_onehot = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_found && req_valid_i[j] && (((int'(ptr) + i) % N_REQ) == j)) begin
          win_found     = 1'b1;
          win_onehot[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_idx   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant_o[j]) begin
        own_valid = req_valid_i[j];
        own_last  = req_last_i[j];
        own_data  = req_data_i[j*DATA_SIZE +: DATA_SIZE];
        own_idx   = PTR_W'(j);
      end
    end
  end

  // The output stage can take a new flit when empty or when its flit drains this cycle.
  assign can_load    = !out_valid_o || out_ready_i;
  assign transfer    = (state == LOCKED) && own_valid && can_load;
  assign req_ready_o = ((state == LOCKED) && can_load) ? grant_o : '0;
  assign busy_o      = (state == LOCKED);

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant_o;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = LOCKED;
          grant_next = win_onehot;
        end
      end
      LOCKED: begin
        if (transfer && own_last) begin
          state_next = IDLE;
          ptr_next   = own_idx;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= PTR_W'(N_REQ - 1);
      grant_o <= '0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      grant_o <= grant_next;
    end
  end

  // A load in the same cycle as a drain replaces the flit without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (transfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= own_data;
      out_last_o  <= own_last;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Bench for mesh_port_arbiter: table-driven first packet, directed corner sequences,
// and a randomized run against a packet-level reference model.
module tb_mesh_port_arbiter;

  localparam int N  = 5;
  localparam int DW = 37;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_last_i;
  logic [N-1:0]    req_ready_o;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic            out_last_o;
  logic            out_ready_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  mesh_port_arbiter #(.N_REQ(N), .DATA_SIZE(DW), .PTR_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side packet sources: {last, data} per flit in small circular buffers.
  logic [DW:0]   src_mem [N][64];
  int            src_head [N];
  int            src_tail [N];
  logic [N-1:0]  hold;
  int            pushed;
  int            delivered;
  logic [DW-1:0] deliv_log [$];

  // Reference model state, kept at packet/flit level.
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  bit            m_ov;
  bit            m_ol;
  logic [DW-1:0] m_od;

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    int            flit;
    logic          ordy;
    logic [N-1:0]  grant;
    logic [N-1:0]  ready;
    logic          ov;
    logic [DW-1:0] od;
    logic          ol;
    logic          busy;
  } vec_t;

  vec_t table_v [6];

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[3'((p + i) % N)]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant();
    return m_locked ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] model_ready();
    return (m_locked && (!m_ov || out_ready_i)) ? N'(1 << m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = N - 1;
    m_ov     = 0;
    m_ol     = 0;
    m_od     = '0;
  endtask

  task automatic model_update();
    int  w;
    bit  can_load;
    can_load = !m_ov || out_ready_i;
    if (!m_locked) begin
      w = pick(m_ptr, req_valid_i);
      if (out_ready_i) m_ov = 0;
      if (w >= 0) begin
        m_locked = 1;
        m_owner  = w;
      end
    end else if (req_valid_i[3'(m_owner)] && can_load) begin
      m_ov = 1;
      m_od = DW'(req_data_i >> (m_owner * DW));
      m_ol = req_last_i[3'(m_owner)];
      if (m_ol) begin
        m_locked = 0;
        m_ptr    = m_owner;
      end
    end else if (out_ready_i) begin
      m_ov = 0;
    end
  endtask

  task automatic push_packet(input int k, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      src_mem[k][src_tail[k] % 64] = {(i == len - 1), DW'(base + DW'(i))};
      src_tail[k]++;
      pushed++;
    end
  endtask

  function automatic bit sources_empty();
    for (int k = 0; k < N; k++) if (src_head[k] != src_tail[k]) return 0;
    return 1;
  endfunction

  task automatic applyStimulus(input logic ordy);
    out_ready_i = ordy;
    for (int k = 0; k < N; k++) begin
      if (src_head[k] != src_tail[k] && !hold[k]) begin
        req_valid_i[k] = 1'b1;
        {req_last_i[k], req_data_i[k*DW +: DW]} = src_mem[k][src_head[k] % 64];
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'($urandom_range(0, 1));
        req_data_i[k*DW +: DW] = DW'($urandom());
      end
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_grant"}, 64'(grant_o), 64'(model_grant()));
    checkValue({tag, "_ready"}, 64'(req_ready_o), 64'(model_ready()));
    checkValue({tag, "_busy"}, 64'(busy_o), 64'(m_locked));
    checkValue({tag, "_oval"}, 64'(out_valid_o), 64'(m_ov));
    checkValue({tag, "_odata"}, 64'(out_data_o), 64'(m_od));
    checkValue({tag, "_olast"}, 64'(out_last_o), 64'(m_ol));
  endtask

  task automatic advance();
    logic [N-1:0] rdy;
    rdy = model_ready();
    if (out_valid_o && out_ready_i) begin
      delivered++;
      deliv_log.push_back(out_data_o);
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid_i[k] && rdy[k] && src_head[k] != src_tail[k]) src_head[k]++;
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sources();
    for (int k = 0; k < N; k++) begin
      src_head[k] = 0;
      src_tail[k] = 0;
    end
    hold      = '0;
    pushed    = 0;
    delivered = 0;
    deliv_log.delete();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    out_ready_i = 1'b0;
    clear_sources();
    model_reset();
    #1;
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n, input logic ordy, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(ordy);
      checkOutput(tag);
      advance();
    end
  endtask

  initial begin
    int  seen;
    bit  done;
    logic [N-1:0] gexp;

    // Three-flit packet from requester 0; lane k carries k*256 + flit.
    table_v[0] = '{5'b00001, 5'b00000, 1, 1'b1, 5'b00000, 5'b00000, 1'b0, 37'd0, 1'b0, 1'b0};
    table_v[1] = '{5'b00001, 5'b00000, 1, 1'b1, 5'b00001, 5'b00001, 1'b0, 37'd0, 1'b0, 1'b1};
    table_v[2] = '{5'b00001, 5'b00000, 2, 1'b1, 5'b00001, 5'b00001, 1'b1, 37'd1, 1'b0, 1'b1};
    table_v[3] = '{5'b00001, 5'b00001, 3, 1'b1, 5'b00001, 5'b00001, 1'b1, 37'd2, 1'b0, 1'b1};
    table_v[4] = '{5'b00000, 5'b00000, 0, 1'b1, 5'b00000, 5'b00000, 1'b1, 37'd3, 1'b1, 1'b0};
    table_v[5] = '{5'b00000, 5'b00000, 0, 1'b1, 5'b00000, 5'b00000, 1'b0, 37'd3, 1'b1, 1'b0};

    do_reset();
    for (int r = 0; r < 6; r++) begin
      req_valid_i = table_v[r].valid;
      req_last_i  = table_v[r].last;
      out_ready_i = table_v[r].ordy;
      for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = DW'(k * 256 + table_v[r].flit);
      #1;
      checkOutput("t1_model");
      checkValue("t1_grant", 64'(grant_o), 64'(table_v[r].grant));
      checkValue("t1_ready", 64'(req_ready_o), 64'(table_v[r].ready));
      checkValue("t1_oval", 64'(out_valid_o), 64'(table_v[r].ov));
      checkValue("t1_odata", 64'(out_data_o), 64'(table_v[r].od));
      checkValue("t1_olast", 64'(out_last_o), 64'(table_v[r].ol));
      checkValue("t1_busy", 64'(busy_o), 64'(table_v[r].busy));
      advance();
    end

    // All requesters continuously valid with single-flit packets.
    do_reset();
    for (int k = 0; k < N; k++) begin
      push_packet(k, 1, DW'(k * 16));
      push_packet(k, 1, DW'(k * 16 + 8));
    end
    for (int p = 0; p < 6; p++) begin
      applyStimulus(1'b1);
      checkOutput("t2");
      checkValue("t2_idle_gap", 64'(grant_o), 64'(0));
      advance();
      applyStimulus(1'b1);
      checkOutput("t2");
      gexp = N'(1 << (p % N));
      checkValue("t2_order", 64'(grant_o), 64'(gexp));
      advance();
    end
    run_cycles(12, 1'b1, "t2_tail");

    // Downstream stall in the middle of requester 2's packet.
    do_reset();
    push_packet(2, 3, 37'h2000);
    run_cycles(2, 1'b1, "t3_start");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      checkOutput("t3_stall");
      checkValue("t3_ready_stall", 64'(req_ready_o[2]), 64'(0));
      checkValue("t3_hold", 64'(out_data_o), 64'(37'h2000));
      advance();
    end
    run_cycles(8, 1'b1, "t3_resume");
    checkValue("t3_count", 64'(deliv_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < deliv_log.size(); i++)
      checkValue("t3_stream", 64'(deliv_log[i]), 64'(37'h2000 + 37'(i)));

    // Owner 3 pauses mid-packet while requester 1 waits.
    do_reset();
    push_packet(3, 4, 37'h3000);
    run_cycles(1, 1'b1, "t4_arb");
    push_packet(1, 1, 37'h1000);
    run_cycles(1, 1'b1, "t4_first");
    hold[3] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1);
      checkOutput("t4_pause");
      checkValue("t4_grant_held", 64'(grant_o), 64'(5'b01000));
      checkValue("t4_no_ready1", 64'(req_ready_o[1]), 64'(0));
      advance();
    end
    hold[3] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      applyStimulus(1'b1);
      checkOutput("t4_resume");
      if (grant_o == 5'b00010) begin
        seen = 1;
        checkValue("t4_pkt3_done_first", 64'(src_tail[3] - src_head[3]), 64'(0));
      end
      advance();
    end
    checkValue("t4_req1_granted", 64'(seen), 64'(1));
    run_cycles(4, 1'b1, "t4_tail");

    // Asynchronous reset during the second flit of a 4-flit packet.
    do_reset();
    push_packet(0, 4, 37'h0100);
    run_cycles(2, 1'b1, "t5_pre");
    applyStimulus(1'b1);
    checkOutput("t5_mid");
    rst = 1'b1;
    #1;
    checkValue("t5_async_grant", 64'(grant_o), 64'(0));
    checkValue("t5_async_ready", 64'(req_ready_o), 64'(0));
    checkValue("t5_async_oval", 64'(out_valid_o), 64'(0));
    checkValue("t5_async_odata", 64'(out_data_o), 64'(0));
    checkValue("t5_async_olast", 64'(out_last_o), 64'(0));
    checkValue("t5_async_busy", 64'(busy_o), 64'(0));
    clear_sources();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_packet(4, 1, 37'h0400);
    push_packet(0, 1, 37'h0001);
    run_cycles(1, 1'b1, "t5_arb");
    applyStimulus(1'b1);
    checkOutput("t5_after");
    checkValue("t5_winner", 64'(grant_o), 64'(5'b00001));
    advance();
    run_cycles(6, 1'b1, "t5_tail");

    // Requester 4 finishes while requesters 0 and 4 both have packets waiting.
    do_reset();
    push_packet(4, 1, 37'h0440);
    push_packet(4, 1, 37'h0441);
    run_cycles(1, 1'b1, "t6_arb");
    push_packet(0, 1, 37'h0007);
    applyStimulus(1'b1);
    checkOutput("t6_own4");
    checkValue("t6_owner4", 64'(grant_o), 64'(5'b10000));
    advance();
    run_cycles(1, 1'b1, "t6_idle");
    applyStimulus(1'b1);
    checkOutput("t6_next");
    checkValue("t6_next_is_0", 64'(grant_o), 64'(5'b00001));
    advance();
    run_cycles(6, 1'b1, "t6_tail");

    // Randomized traffic, stalls and valid drops against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if (src_tail[k] - src_head[k] <= 56)
          push_packet(k, $urandom_range(1, 4), DW'({$urandom(), $urandom()}));
      end
      for (int k = 0; k < N; k++) hold[k] = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 3) != 0);
      checkOutput("rand");
      advance();
    end
    hold = '0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      applyStimulus(1'b1);
      checkOutput("drain");
      advance();
      done = sources_empty() && !m_locked && !m_ov;
    end
    checkValue("rand_drained", 64'(done), 64'(1));
    checkValue("rand_flit_count", 64'(delivered), 64'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
